dsp_echo_engine: RTL and testbench

- Parametrised successor to the lab-3 DSP path: per-sample mode mux with bypass, external FIR pass-through, feed-forward echo and feedback (recirculating) echo.
- Uses a circular RAM delay line with programmable delay, programmable attenuation and saturating signed arithmetic.
- Runs an automatic buffer-clear sequencer after reset and on request.
- Sits between the audio codec sample interface and the output DAC path; the FIR filter stays external and feeds fir_sample.

---
 rtl/dsp_echo_pkg.sv | 21 ++
 rtl/echo_delay_ram.sv | 21 ++
 rtl/dsp_echo_engine.sv | 110 +++++++++++
 tb/tb_dsp_echo_engine.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dsp_echo_pkg.sv
// dsp_echo_pkg: mode codes, FSM states and the saturating adder shared by the echo engine.
package dsp_echo_pkg;
    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_FIR    = 2'b01;
    localparam logic [1:0] MODE_FF     = 2'b10;
    localparam logic [1:0] MODE_FB     = 2'b11;
    localparam int SAT_W = 32;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // Adds two sign-extended operands and clamps to the signed range of a w-bit result (w <= SAT_W).
    function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                         input logic signed [SAT_W-1:0] b,
                                                         input int w);
        logic signed [SAT_W:0] s;
        logic signed [SAT_W:0] hi;
        s  = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi = ({{SAT_W{1'b0}}, 1'b1} << (w - 1)) - {{SAT_W{1'b0}}, 1'b1};
        return (s > hi) ? hi[SAT_W-1:0] : (s < ~hi) ? ~hi[SAT_W-1:0] : s[SAT_W-1:0];
    endfunction
endpackage

// File: rtl/echo_delay_ram.sv
// echo_delay_ram: DEPTH x WIDTH delay line, one write port and an asynchronous read port.
module echo_delay_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/dsp_echo_engine.sv
// dsp_echo_engine: per-sample bypass/FIR/feed-forward/feedback echo over a circular delay line,
// with a sequencer that zeroes the line after reset and on request.
module dsp_echo_engine
    import dsp_echo_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 10,
    parameter int SHIFT_W = 3
) (
    input  logic               sample_clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [1:0]         selector,
    input  logic [ADDR_W-1:0]  delay_len,
    input  logic [SHIFT_W-1:0] atten_shift,
    input  logic               clear,
    input  logic [WIDTH-1:0]   input_sample,
    input  logic [WIDTH-1:0]   fir_sample,
    output logic [WIDTH-1:0]   output_sample,
    output logic               out_valid,
    output logic               sat_flag,
    output logic               busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d, clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d, sat_q, sat_d;
    logic               we;
    logic [ADDR_W-1:0]  waddr, raddr;
    logic [WIDTH-1:0]   wdata, rdata, y;
    logic signed [WIDTH-1:0] x, e, y_sat;
    logic signed [WIDTH:0]   sum;
    logic               echo_mode, sat_hit;

    // delay_len==0 wraps to DEPTH, which is the same address as subtracting zero mod DEPTH.
    assign raddr     = wr_ptr_q - delay_len;
    assign x         = input_sample;
    assign e         = $signed(rdata) >>> atten_shift;
    assign sum       = {x[WIDTH-1], x} + {e[WIDTH-1], e};
    assign y_sat     = WIDTH'(sat_add(SAT_W'(x), SAT_W'(e), WIDTH));
    assign sat_hit   = sum != {y_sat[WIDTH-1], y_sat};
    assign echo_mode = (selector == MODE_FF) || (selector == MODE_FB);
    assign y         = (selector == MODE_BYPASS) ? x : (selector == MODE_FIR) ? fir_sample : y_sat;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        clr_cnt_d   = clr_cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sat_d       = sat_q;
        we          = 1'b0;
        waddr       = wr_ptr_q;
        wdata       = x;
        if (state_q == ST_CLEAR) begin
            we        = 1'b1;
            waddr     = clr_cnt_q;
            wdata     = '0;
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d  = ST_RUN;
                wr_ptr_d = '0;
            end
        end else if (clear) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
        end else if (in_valid) begin
            we          = 1'b1;
            wdata       = (selector == MODE_FB) ? y_sat : x;
            out_d       = y;
            sat_d       = echo_mode && sat_hit;
            out_valid_d = 1'b1;
            wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge sample_clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            wr_ptr_q    <= '0;
            clr_cnt_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    echo_delay_ram #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (sample_clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign output_sample = out_q;
    assign out_valid     = out_valid_q;
    assign sat_flag      = sat_q;
    assign busy          = state_q == ST_CLEAR;
endmodule

// File: tb/tb_dsp_echo_engine.sv
// tb_dsp_echo_engine: scoreboard bench for dsp_echo_engine with a 16-entry delay line.
module tb_dsp_echo_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  selector = 2'b00;
    logic [3:0]  delay_len = 4'd0;
    logic [2:0]  atten_shift = 3'd0;
    logic        clear = 1'b0;
    logic [15:0] input_sample = '0;
    logic [15:0] fir_sample = '0;
    logic [15:0] output_sample;
    logic        out_valid, sat_flag, busy;

    int checks = 0;
    int errors = 0;
    string phase = "reset";
    logic [16:0] sb [$];

    dsp_echo_engine #(.WIDTH(16), .ADDR_W(4), .SHIFT_W(3)) dut (
        .sample_clock  (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .selector      (selector),
        .delay_len     (delay_len),
        .atten_shift   (atten_shift),
        .clear         (clear),
        .input_sample  (input_sample),
        .fir_sample    (fir_sample),
        .output_sample (output_sample),
        .out_valid     (out_valid),
        .sat_flag      (sat_flag),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s phase=%s got=%h exp=%h", tag, phase, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) chk("extra_valid", 32'd1, 32'd0);
            else chk("out_sat", {15'd0, sat_flag, output_sample}, {15'd0, sb.pop_front()});
        end
    end

    task automatic send(input int x, input int fir, input int y, input bit s);
        input_sample = 16'(x);
        fir_sample   = 16'(fir);
        in_valid     = 1'b1;
        sb.push_back({s, 16'(y)});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        selector = 2'b00;
        repeat (16) send(0, 0, 0, 1'b0);
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk(tag, n, 16);
    endtask

    int fb_exp[10] = '{1024, 0, 512, 0, 256, 0, 128, 0, 64, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", output_sample, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_busy", busy, 1);
        reset = 1'b0;
        in_valid = 1'b1;
        input_sample = 16'h7777;
        count_busy("busy_after_reset");
        in_valid = 1'b0;

        phase = "ff_d5";
        selector = 2'b10; delay_len = 4'd5; atten_shift = 3'd2;
        send(1000, 0, 1000, 1'b0);
        for (int i = 1; i < 10; i++) send(0, 0, (i == 5) ? 250 : 0, 1'b0);

        phase = "bypass_fir";
        selector = 2'b00;
        send(16'h1234, 16'h5555, 16'h1234, 1'b0);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", output_sample, 16'h1234);
        selector = 2'b01;
        send(55, 16'h0F0F, 16'h0F0F, 1'b0);
        flush();

        phase = "ff_d3";
        selector = 2'b10; delay_len = 4'd3; atten_shift = 3'd1;
        for (int i = 0; i < 7; i++) send((i == 0) ? 1000 : 0, 0, (i == 0) ? 1000 : (i == 3) ? 500 : 0, 1'b0);
        flush();

        phase = "ff_d3_gaps";
        selector = 2'b10;
        for (int i = 0; i < 7; i++) begin
            send((i == 0) ? 1000 : 0, 0, (i == 0) ? 1000 : (i == 3) ? 500 : 0, 1'b0);
            idle(2);
            chk("gap_hold_valid", out_valid, 0);
        end
        flush();

        phase = "fb_d2";
        selector = 2'b11; delay_len = 4'd2; atten_shift = 3'd1;
        for (int i = 0; i < 10; i++) send((i == 0) ? 1024 : 0, 0, fb_exp[i], 1'b0);
        flush();

        phase = "fb_d16";
        selector = 2'b11; delay_len = 4'd0; atten_shift = 3'd0;
        for (int i = 0; i < 17; i++) send((i == 0) ? 100 : 0, 0, (i == 0 || i == 16) ? 100 : 0, 1'b0);
        flush();

        phase = "saturate";
        selector = 2'b10; delay_len = 4'd1; atten_shift = 3'd0;
        send(30000, 0, 30000, 1'b0);
        send(30000, 0, 32767, 1'b1);
        send(-30000, 0, 0, 1'b0);
        send(-30000, 0, -32768, 1'b1);
        atten_shift = 3'd7;
        send(0, 0, -235, 1'b0);

        phase = "mid_clear";
        selector = 2'b00;
        repeat (16) send(5000, 0, 5000, 1'b0);
        clear = 1'b1; in_valid = 1'b1; input_sample = 16'd1234;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("clr_busy", busy, 1);
        count_busy("busy_after_clear");
        in_valid = 1'b0;
        selector = 2'b10; delay_len = 4'd7; atten_shift = 3'd0;
        repeat (16) send(0, 0, 0, 1'b0);

        phase = "reset_in_clear";
        selector = 2'b00;
        repeat (16) send(5000, 0, 5000, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_busy", busy, 1);
        chk("async_valid", out_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        count_busy("busy_after_midclear_reset");
        selector = 2'b10; delay_len = 4'd0; atten_shift = 3'd0;
        repeat (16) send(0, 0, 0, 1'b0);

        idle(3);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
